// File: rtl/mul_wbq_pkg.sv
// mul_wbq_pkg: shared types and sizes for the multiplier writeback queue; widths fall back to defaults when machine.vh is absent.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 7
`endif
package mul_wbq_pkg;
  localparam int MUL_WBQ_DEPTH = 4;
  localparam int MUL_WBQ_LG_DEPTH = 2;
  localparam int M_W = `M_WIDTH;
  localparam int ROB_W = `LG_ROB_ENTRIES;
  localparam int PRF_W = `LG_PRF_ENTRIES;
  typedef struct packed {
    logic [M_W-1:0] y;
    logic [ROB_W-1:0] rob_ptr;
    logic prf_val;
    logic [PRF_W-1:0] prf_ptr;
  } mul_wb_t;
endpackage

// File: rtl/wbq_fifo.sv
// wbq_fifo: circular FIFO of mul_wb_t with head/tail/count; a push while full is accepted only alongside a pop.
import mul_wbq_pkg::*;
module wbq_fifo #(
  parameter int DEPTH = MUL_WBQ_DEPTH,
  parameter int LG_DEPTH = MUL_WBQ_LG_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  mul_wb_t din,
  output mul_wb_t dout,
  output logic full,
  output logic empty,
  output logic [LG_DEPTH:0] count
);
  localparam int PW = (LG_DEPTH > 0) ? LG_DEPTH : 1;
  logic [PW-1:0] head, tail;
  logic do_push, do_pop;
  mul_wb_t mem [DEPTH];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full = count == (LG_DEPTH+1)'(DEPTH);
    empty = count == '0;
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout = mem[head];
  end
  always_ff @(posedge clk) if (do_push) mem[tail] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= nxt(tail);
      if (do_pop) head <= nxt(head);
      count <= count + (LG_DEPTH+1)'(do_push) - (LG_DEPTH+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mul_wb_queue.sv
// mul_wb_queue: credit-gated writeback buffer for multiplier results; MUL_WBQ_BYPASS_EN adds an empty-queue same-cycle bypass.
import mul_wbq_pkg::*;
module mul_wb_queue #(
  parameter int DEPTH = MUL_WBQ_DEPTH,
  parameter int LG_DEPTH = MUL_WBQ_LG_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic issue_go,
  input  logic mul_complete,
  input  logic [M_W-1:0] mul_y,
  input  logic [ROB_W-1:0] mul_rob_ptr,
  input  logic mul_prf_val,
  input  logic [PRF_W-1:0] mul_prf_ptr,
  input  logic wb_grant,
  output logic wb_req,
  output logic [M_W-1:0] wb_y,
  output logic [ROB_W-1:0] wb_rob_ptr,
  output logic wb_prf_val,
  output logic [PRF_W-1:0] wb_prf_ptr,
  output logic mul_can_issue,
  output logic overflow_err
);
  mul_wb_t in_e, head_e, out_e;
  logic full, empty, byp, push, ovf;
  logic [LG_DEPTH:0] count, inflight;
  assign in_e = '{y: mul_y, rob_ptr: mul_rob_ptr, prf_val: mul_prf_val, prf_ptr: mul_prf_ptr};
  wbq_fifo #(.DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(wb_grant), .din(in_e),
    .dout(head_e), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
`ifdef MUL_WBQ_BYPASS_EN
    byp = empty & mul_complete;
    out_e = byp ? in_e : head_e;
`else
    byp = 1'b0;
    out_e = head_e;
`endif
    wb_req = ~empty | byp;
    push = mul_complete & ~(byp & wb_grant);
    ovf = mul_complete & ((full & ~wb_grant) | (inflight == '0));
    {wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr} = out_e;
    mul_can_issue = ({1'b0, inflight} + {1'b0, count}) < (LG_DEPTH+2)'(DEPTH);
  end
  // A completion with no op in flight is a protocol error; the counter holds at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      overflow_err <= 1'b0;
    end else begin
      inflight <= inflight + (LG_DEPTH+1)'(issue_go) - (LG_DEPTH+1)'(mul_complete & (inflight != '0));
      if (ovf) overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_wb_queue.sv
// tb_mul_wb_queue: directed and random checks of mul_wb_queue against a queue-based reference model.
import mul_wbq_pkg::*;
module tb_mul_wb_queue;
`ifdef MUL_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = MUL_WBQ_DEPTH;
  logic clk = 1'b0, reset = 1'b1, issue_go = 1'b0, mul_complete = 1'b0, wb_grant = 1'b0;
  logic [M_W-1:0] mul_y = '0;
  logic [ROB_W-1:0] mul_rob_ptr = '0;
  logic mul_prf_val = 1'b0;
  logic [PRF_W-1:0] mul_prf_ptr = '0;
  logic wb_req, wb_prf_val, mul_can_issue, overflow_err;
  logic [M_W-1:0] wb_y;
  logic [ROB_W-1:0] wb_rob_ptr;
  logic [PRF_W-1:0] wb_prf_ptr;
  int n_chk = 0, n_fail = 0;
  mul_wb_t mq[$];
  int m_inf = 0;
  bit m_err = 1'b0;
  mul_wb_t z = '0;
  always #5 clk = ~clk;
  mul_wb_queue dut (
    .clk(clk), .reset(reset), .issue_go(issue_go), .mul_complete(mul_complete),
    .mul_y(mul_y), .mul_rob_ptr(mul_rob_ptr), .mul_prf_val(mul_prf_val), .mul_prf_ptr(mul_prf_ptr),
    .wb_grant(wb_grant), .wb_req(wb_req), .wb_y(wb_y), .wb_rob_ptr(wb_rob_ptr),
    .wb_prf_val(wb_prf_val), .wb_prf_ptr(wb_prf_ptr), .mul_can_issue(mul_can_issue),
    .overflow_err(overflow_err)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  function automatic mul_wb_t rd();
    mul_wb_t d;
    d.y = M_W'({$urandom, $urandom});
    d.rob_ptr = ROB_W'($urandom);
    d.prf_val = 1'($urandom);
    d.prf_ptr = PRF_W'($urandom);
    return d;
  endfunction
  function automatic mul_wb_t mk(input logic [M_W-1:0] y, input int rob, input int prf);
    mul_wb_t d;
    d.y = y;
    d.rob_ptr = ROB_W'(rob);
    d.prf_val = 1'b1;
    d.prf_ptr = PRF_W'(prf);
    return d;
  endfunction
  // Called just after a falling edge: drive, check outputs, then advance the model on the rising edge.
  task automatic step(input bit i, input bit c, input bit g, input mul_wb_t d);
    bit bp, req;
    issue_go = i;
    mul_complete = c;
    wb_grant = g;
    {mul_y, mul_rob_ptr, mul_prf_val, mul_prf_ptr} = d;
    #1;
    bp = BYP && mq.size() == 0 && c;
    req = mq.size() > 0 || bp;
    chk("wb_req", 128'(wb_req), 128'(req));
    if (req) chk("wb_data", 128'({wb_y, wb_rob_ptr, wb_prf_val, wb_prf_ptr}), 128'(mq.size() > 0 ? mq[0] : d));
    chk("can_issue", 128'(mul_can_issue), 128'((m_inf + mq.size()) < DEPTH));
    chk("overflow_err", 128'(overflow_err), 128'(m_err));
    @(posedge clk);
    if (mq.size() > 0 && g) void'(mq.pop_front());
    if (c && !(bp && g)) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_err = 1'b1;
    end
    if (c) begin
      if (m_inf == 0) m_err = 1'b1;
      else m_inf--;
    end
    if (i) m_inf++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    issue_go = 1'b0;
    mul_complete = 1'b0;
    wb_grant = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_inf = 0;
    m_err = 1'b0;
  endtask
  initial begin
    int cyc;
    int due[$];
    bit c, i;
    @(negedge clk);
    do_reset();
    step(0, 0, 0, z);
    // single op with writeback granted on arrival
    step(1, 0, 1, z);
    step(0, 0, 1, z);
    step(0, 0, 1, z);
    step(0, 1, 1, mk(64'h1234, 5, 9));
    step(0, 0, 1, z);
    step(0, 0, 1, z);
    // fill to depth with no grant, then force one extra issue
    for (int k = 0; k < 4; k++) step(1, 0, 0, z);
    for (int k = 0; k < 4; k++) step(0, 1, 0, rd());
    step(1, 0, 0, z);
    step(0, 1, 1, rd());
    for (int k = 0; k < 3; k++) step(0, 0, 1, z);
    for (int k = 0; k < 2; k++) step(1, 0, 1, z);
    for (int k = 0; k < 2; k++) step(0, 1, 0, rd());
    // wrapped pointers: refill to full and drain past index 3
    for (int k = 0; k < 4; k++) step(1, 0, 1, z);
    for (int k = 0; k < 4; k++) step(0, 1, 0, rd());
    step(0, 1, 0, rd());
    for (int k = 0; k < 3; k++) step(0, 0, 0, z);
    for (int k = 0; k < 5; k++) step(0, 0, 1, z);
    // reset with stored entries and ops in flight
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 0, 0, z);
    for (int k = 0; k < 3; k++) step(0, 1, 0, rd());
    for (int k = 0; k < 2; k++) step(1, 0, 0, z);
    do_reset();
    step(0, 0, 0, z);
    // empty-queue arrival, granted and then not granted
    step(1, 0, 0, z);
    step(1, 0, 0, z);
    step(0, 1, 1, rd());
    step(0, 1, 0, rd());
    step(0, 0, 0, z);
    step(0, 0, 1, z);
    step(0, 0, 0, z);
    // random traffic honouring the credit output, fixed 3-cycle multiplier latency
    do_reset();
    cyc = 0;
    for (int k = 0; k < 600; k++) begin
      c = due.size() > 0 && due[0] == cyc;
      if (c) void'(due.pop_front());
      i = ((m_inf + mq.size()) < DEPTH) && $urandom_range(1, 0) == 1;
      if (i) due.push_back(cyc + 3);
      step(i, c, $urandom_range(2, 0) != 0, c ? rd() : z);
      cyc++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
